vresp_order_queue: RTL
======================

VRESP_ORDER_QUEUE -- requirements
Module: vresp_order_queue

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4, meaning number of response sources (2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning response data width.
REQ-003 SHALL have parameter DATA_DEPTH, default 8, meaning per-port data FIFO depth (power of 2, >=2).
REQ-004 SHALL have parameter ORDER_DEPTH, default 32, meaning issue-order FIFO depth (power of 2, >=2).
REQ-005 SHALL have port clk  input  1  clock, with rst (synchronous, active-high).
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port issue_valid  input  1  instruction issued, response owed.
REQ-008 SHALL have port issue_port  input  PW=$clog2(NUM_PORTS)  source that will answer.
REQ-009 SHALL have port issue_ready  output  1  order FIFO can accept an entry.
REQ-010 SHALL have port port_valid  input  NUM_PORTS  per-source data push.
REQ-011 SHALL have port port_data  input  NUM_PORTS*DATA_WIDTH  packed per-source data, port p at [p*DATA_WIDTH +: DATA_WIDTH].
REQ-012 SHALL have port port_ready  output  NUM_PORTS  per-source FIFO not full.
REQ-013 SHALL have port resp_valid  output  1  in-order response available.
REQ-014 SHALL have port resp_data  output  DATA_WIDTH  response data.
REQ-015 SHALL have port resp_ready  input  1  consumer accepts response.
REQ-016 SHALL have port flush  input  1  discard all pending state.
REQ-017 SHALL have port outstanding  output  $clog2(ORDER_DEPTH)+1  order FIFO occupancy.
REQ-018 SHALL have port err_overflow  output  NUM_PORTS  sticky per-port push-while-full flag.

Function
REQ-019 Issue accepted when issue_valid & issue_ready; issue_port written to order FIFO tail.
REQ-020 issue_ready SHALL be 1 iff order FIFO not full; no same-cycle pop bypass.
REQ-021 Port p push accepted when port_valid[p] & port_ready[p]; port_ready[p] = data FIFO p not full; no bypass.
REQ-022 resp_valid SHALL be 1 iff order FIFO non-empty and data FIFO[head port] non-empty; resp_data = head of that FIFO, else 0.
REQ-023 Handshake resp_valid & resp_ready SHALL pop order FIFO head and data FIFO[head port] in the same cycle.
REQ-024 Latency: data pushed in cycle N with matching head SHALL be visible on resp_valid in cycle N+1; issue pushed in N likewise visible N+1.
REQ-025 resp_valid SHALL remain asserted and resp_data stable while resp_ready low.
REQ-026 Data arriving before its issue entry SHALL be buffered, not dropped.
REQ-027 Simultaneous issue push and response pop SHALL leave outstanding unchanged.
REQ-028 port_valid[p] while port_ready[p]=0 SHALL set err_overflow[p]; data discarded; cleared only by rst.
REQ-029 issue_valid while issue_ready=0 SHALL be ignored (no error flag).
REQ-030 flush SHALL empty all FIFOs in the next cycle, overriding same-cycle pushes/pops; err_overflow retained.
REQ-031 Pointers wrap modulo depth; full/empty decided by count, not pointer equality.
REQ-032 issue_port >= NUM_PORTS SHALL be treated as port 0.

Reset
REQ-033 rst SHALL clear all FIFOs, outstanding=0, err_overflow=0; outputs: resp_valid=0, resp_data=0, issue_ready=1, port_ready=all 1.
REQ-034 rst mid-operation SHALL discard all entries; rst dominates flush.

Structure
REQ-035 Port-index type and default depth constants SHALL live in rvvLitePkg.
REQ-036 One sub-module vresp_sync_fifo (parametrised width/depth, push/pop/valid/full/count) SHALL be instantiated NUM_PORTS+1 times.

Verification
REQ-037 Issue ports 2,0,1; data arrives port1=0x11, port0=0x22, port2=0x33 -> outputs 0x33,0x22,0x11 in that order.
REQ-038 Hold resp_ready=0 3 cycles with head valid 0xAB -> resp_valid=1, resp_data=0xAB stable, outstanding unchanged, pop on release.
REQ-039 9 pushes to port 3 (DATA_DEPTH=8) without pops -> port_ready[3]=0 after 8th, err_overflow[3]=1 after 9th.
REQ-040 32 issues without response -> issue_ready=0, outstanding=32; 33rd issue ignored.
REQ-041 Flush with 5 pending entries and simultaneous push -> next cycle outstanding=0, resp_valid=0.
REQ-042 rst asserted mid-stream with err_overflow set -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/rvvLitePkg.sv
// Shared definitions for the in-order vector response queue.
//
// Contents:
//   MAX_PORTS / PORT_IDX_W : upper bound on response sources and its index width
//   port_idx_t             : source index stored in the issue-order FIFO
//   DEF_*                  : default sizing used by the queue and its interface
//   clamp_port()           : maps an out-of-range source index to port 0
package rvvLitePkg;

    localparam int MAX_PORTS  = 8;
    localparam int PORT_IDX_W = $clog2(MAX_PORTS);

    typedef logic [PORT_IDX_W-1:0] port_idx_t;

    localparam int DEF_NUM_PORTS   = 4;
    localparam int DEF_DATA_WIDTH  = 32;
    localparam int DEF_DATA_DEPTH  = 8;
    localparam int DEF_ORDER_DEPTH = 32;

    // A source index that names no real port is redirected to port 0 so the
    // order FIFO never points at a data FIFO that does not exist.
    function automatic port_idx_t clamp_port(input port_idx_t p, input int unsigned num_ports);
        return (32'(p) >= num_ports) ? '0 : p;
    endfunction

endpackage

// File: rtl/vresp_order_queue_if.sv
// Bus bundle for vresp_order_queue.
//
// Handshakes (all three channels): a transfer happens in a cycle where both
// valid and ready are high at the rising clk edge. A producer may assert valid
// regardless of ready; ready never depends on the same-cycle valid. resp_valid
// stays high and resp_data stays stable until resp_ready is seen.
//
// Signals:
//   issue_valid/issue_port/issue_ready : issued instruction, source owing data
//   port_valid/port_data/port_ready    : per-source data pushes (packed data)
//   resp_valid/resp_data/resp_ready    : in-order response stream
//   flush                              : discard all pending entries
//   outstanding                        : issue-order FIFO occupancy
//   err_overflow                       : sticky per-port push-while-full flags
// Modports: master = environment driving the queue, slave = the queue itself.
interface vresp_order_queue_if
    import rvvLitePkg::*;
#(
    parameter int NUM_PORTS   = DEF_NUM_PORTS,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int ORDER_DEPTH = DEF_ORDER_DEPTH
);
    localparam int PW  = $clog2(NUM_PORTS);
    localparam int OCW = $clog2(ORDER_DEPTH) + 1;

    logic                            issue_valid;
    logic [PW-1:0]                   issue_port;
    logic                            issue_ready;
    logic [NUM_PORTS-1:0]            port_valid;
    logic [NUM_PORTS*DATA_WIDTH-1:0] port_data;
    logic [NUM_PORTS-1:0]            port_ready;
    logic                            resp_valid;
    logic [DATA_WIDTH-1:0]           resp_data;
    logic                            resp_ready;
    logic                            flush;
    logic [OCW-1:0]                  outstanding;
    logic [NUM_PORTS-1:0]            err_overflow;

    modport master (
        output issue_valid, issue_port, port_valid, port_data, resp_ready, flush,
        input  issue_ready, port_ready, resp_valid, resp_data, outstanding, err_overflow
    );

    modport slave (
        input  issue_valid, issue_port, port_valid, port_data, resp_ready, flush,
        output issue_ready, port_ready, resp_valid, resp_data, outstanding, err_overflow
    );

endinterface

// File: rtl/vresp_sync_fifo.sv
// Synchronous FIFO with count-based full/empty and combinational head read.
//
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   clr             : synchronous clear, overrides same-cycle push/pop
//   push, push_data : write request, ignored while full (no bypass)
//   pop, pop_data   : read request, ignored while empty; pop_data is the head
//   valid, full     : non-empty / full status
//   count           : occupancy 0..DEPTH
module vresp_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     valid,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Occupancy alone decides full/empty, so pointer equality is never ambiguous.
    assign full     = (count == CW'(DEPTH));
    assign valid    = (count != '0);
    assign do_push  = push & ~full;
    assign do_pop   = pop & valid;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/vresp_order_queue.sv
// Reorders responses from several sources back into instruction issue order.
// Each issued instruction records which source will answer; each source
// buffers its data in its own FIFO. The response channel presents the data of
// the oldest issued instruction as soon as that source has produced it.
//
// Ports:
//   clk, rst : clock, synchronous active-high reset (dominates flush)
//   bus      : vresp_order_queue_if slave modport (issue, per-port data,
//              response, flush, outstanding count, sticky overflow flags)
module vresp_order_queue
    import rvvLitePkg::*;
#(
    parameter int NUM_PORTS   = DEF_NUM_PORTS,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int DATA_DEPTH  = DEF_DATA_DEPTH,
    parameter int ORDER_DEPTH = DEF_ORDER_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst,
    vresp_order_queue_if.slave   bus
);
    localparam int OCW = $clog2(ORDER_DEPTH) + 1;
    localparam int DCW = $clog2(DATA_DEPTH) + 1;

    port_idx_t             issue_idx;
    port_idx_t             order_head;
    logic                  order_valid;
    logic                  order_full;
    logic [OCW-1:0]        order_count;

    // Per-port status padded to MAX_PORTS so the head index selects directly.
    logic [MAX_PORTS-1:0]  data_valid;
    logic [DATA_WIDTH-1:0] data_head [MAX_PORTS];
    logic [NUM_PORTS-1:0]  data_full;
    logic [NUM_PORTS-1:0]  data_pop;
    logic [DCW-1:0]        data_count_unused [NUM_PORTS];

    logic                  resp_fire;
    logic [NUM_PORTS-1:0]  err_q;

    assign issue_idx = clamp_port(port_idx_t'(bus.issue_port), NUM_PORTS);

    vresp_sync_fifo #(
        .WIDTH (PORT_IDX_W),
        .DEPTH (ORDER_DEPTH)
    ) u_order_fifo (
        .clk       (clk),
        .rst       (rst),
        .clr       (bus.flush),
        .push      (bus.issue_valid),
        .push_data (issue_idx),
        .pop       (resp_fire),
        .pop_data  (order_head),
        .valid     (order_valid),
        .full      (order_full),
        .count     (order_count)
    );

    for (genvar p = 0; p < MAX_PORTS; p++) begin : g_port
        if (p < NUM_PORTS) begin : g_used
            vresp_sync_fifo #(
                .WIDTH (DATA_WIDTH),
                .DEPTH (DATA_DEPTH)
            ) u_data_fifo (
                .clk       (clk),
                .rst       (rst),
                .clr       (bus.flush),
                .push      (bus.port_valid[p]),
                .push_data (bus.port_data[p*DATA_WIDTH +: DATA_WIDTH]),
                .pop       (data_pop[p]),
                .pop_data  (data_head[p]),
                .valid     (data_valid[p]),
                .full      (data_full[p]),
                .count     (data_count_unused[p])
            );
            // Only the FIFO named by the order head is consumed on a response.
            assign data_pop[p] = resp_fire && (order_head == port_idx_t'(p));
        end else begin : g_absent
            assign data_valid[p] = 1'b0;
            assign data_head[p]  = '0;
        end
    end

    assign bus.resp_valid  = order_valid & data_valid[order_head];
    assign resp_fire       = bus.resp_valid & bus.resp_ready;
    assign bus.resp_data   = bus.resp_valid ? data_head[order_head] : '0;
    assign bus.issue_ready = ~order_full;
    assign bus.port_ready  = ~data_full;
    assign bus.outstanding = order_count;
    assign bus.err_overflow = err_q;

    // Sticky overflow flags survive flush; only reset clears them.
    always_ff @(posedge clk) begin
        if (rst) err_q <= '0;
        else     err_q <= err_q | (bus.port_valid & data_full);
    end

endmodule
